// File: rtl/atan2_pkg.sv
// Shared constants and helpers for the CORDIC atan2 engine.
// Angles are signed Q3.13 radians throughout.
package atan2_pkg;

  typedef logic signed [15:0] angle_t;

  localparam angle_t PI         = 16'sh6488;
  localparam angle_t NEG_PI     = 16'sh9B78;
  localparam angle_t HALF_PI    = 16'sh3244;
  localparam angle_t PI_QUARTER = 16'sh1922;

  // UQ0.16 reciprocal of the CORDIC gain
  localparam logic [15:0] CORDIC_K = 16'h9B75;

  // Fractional bits below the integer datapath; without them
  // the micro-rotation shifts of small vectors collapse to zero
  // and the angle stops converging.
  localparam int GUARD = 14;

  // round(atan(2^-i) * 8192)
  localparam logic [15:0] ATAN_LUT [0:15] = '{
    16'h1922, 16'h0ED6, 16'h07D7, 16'h03FB,
    16'h01FF, 16'h0100, 16'h0080, 16'h0040,
    16'h0020, 16'h0010, 16'h0008, 16'h0004,
    16'h0002, 16'h0001, 16'h0000, 16'h0000
  };

  function automatic angle_t angle_clamp(input angle_t a);
    angle_t r;
    r = a;
    if (a > PI)
      r = PI;
    else if (a < NEG_PI)
      r = NEG_PI;
    return r;
  endfunction

endpackage

// File: rtl/cordic_vector_stage.sv
// One registered CORDIC vectoring micro-rotation.
// Carries the valid flag and an opaque tag alongside the data.
module cordic_vector_stage
  import atan2_pkg::*;
#(
  parameter int          W     = 32,
  parameter int          SHIFT = 0,
  parameter logic [15:0] ATAN  = 16'h0000,
  parameter int          TW    = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_valid,
  input  logic signed [W-1:0] i_x,
  input  logic signed [W-1:0] i_y,
  input  angle_t              i_z,
  input  logic [TW-1:0]       i_tag,
  output logic                o_valid,
  output logic signed [W-1:0] o_x,
  output logic signed [W-1:0] o_y,
  output angle_t              o_z,
  output logic [TW-1:0]       o_tag
);

  logic signed [W-1:0] w_xs;
  logic signed [W-1:0] w_ys;
  logic                w_ypos;

  assign w_xs   = i_x >>> SHIFT;
  assign w_ys   = i_y >>> SHIFT;
  assign w_ypos = ~i_y[W-1];

  logic                r_valid;
  logic signed [W-1:0] r_x;
  logic signed [W-1:0] r_y;
  angle_t              r_z;
  logic [TW-1:0]       r_tag;

  // Rotate toward the x axis, accumulating the rotated angle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_tag   <= '0;
    end else begin
      r_valid <= i_valid;
      r_tag   <= i_tag;
      if (w_ypos) begin
        r_x <= i_x + w_ys;
        r_y <= i_y - w_xs;
        r_z <= i_z + $signed(ATAN);
      end else begin
        r_x <= i_x - w_ys;
        r_y <= i_y + w_xs;
        r_z <= i_z - $signed(ATAN);
      end
    end
  end

  assign o_valid = r_valid;
  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_z     = r_z;
  assign o_tag   = r_tag;

endmodule

// File: rtl/cordic_atan2.sv
// Pipelined CORDIC vectoring engine: atan2(y,x) and magnitude.
// Pre-rotate, ITERATIONS micro-rotations, gain, output register.
module cordic_atan2
  import atan2_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ITERATIONS = 14,
  parameter int CHAN_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sink_valid,
  input  logic [WIDTH-1:0]  sink_x,
  input  logic [WIDTH-1:0]  sink_y,
  input  logic [CHAN_W-1:0] sink_chan,
  output logic              source_valid,
  output logic [15:0]       source_angle,
  output logic [WIDTH-1:0]  source_mag,
  output logic [CHAN_W-1:0] source_chan
);

  localparam int DW = WIDTH + 2 + GUARD;
  localparam int TW = CHAN_W + 2;
  localparam int PW = DW + 16;

  logic signed [DW-1:0] w_xin;
  logic signed [DW-1:0] w_yin;
  logic                 w_xneg;
  logic                 w_yzero;

  assign w_xin   = {{2{sink_x[WIDTH-1]}}, sink_x, {GUARD{1'b0}}};
  assign w_yin   = {{2{sink_y[WIDTH-1]}}, sink_y, {GUARD{1'b0}}};
  assign w_xneg  = sink_x[WIDTH-1];
  assign w_yzero = (sink_y == '0);

  logic                 r_v0;
  logic signed [DW-1:0] r_x0;
  logic signed [DW-1:0] r_y0;
  angle_t               r_z0;
  logic [TW-1:0]        r_tag0;

  // Fold the left half-plane onto the right, seeding z with +-PI.
  // The y==0 and x<0 flags ride in the tag so exact axis results
  // can be restored after the iterations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0   <= 1'b0;
      r_x0   <= '0;
      r_y0   <= '0;
      r_z0   <= '0;
      r_tag0 <= '0;
    end else begin
      r_v0   <= sink_valid;
      r_tag0 <= {sink_chan, w_yzero, w_xneg};
      if (w_xneg) begin
        r_x0 <= -w_xin;
        r_y0 <= -w_yin;
        r_z0 <= sink_y[WIDTH-1] ? NEG_PI : PI;
      end else begin
        r_x0 <= w_xin;
        r_y0 <= w_yin;
        r_z0 <= '0;
      end
    end
  end

  logic                 w_v   [ITERATIONS+1];
  logic signed [DW-1:0] w_x   [ITERATIONS+1];
  logic signed [DW-1:0] w_y   [ITERATIONS+1];
  angle_t               w_z   [ITERATIONS+1];
  logic [TW-1:0]        w_tag [ITERATIONS+1];

  assign w_v[0]   = r_v0;
  assign w_x[0]   = r_x0;
  assign w_y[0]   = r_y0;
  assign w_z[0]   = r_z0;
  assign w_tag[0] = r_tag0;

  for (genvar g = 0; g < ITERATIONS; g++) begin : g_stage
    cordic_vector_stage #(
      .W     (DW),
      .SHIFT (g),
      .ATAN  (ATAN_LUT[g]),
      .TW    (TW)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_v[g]),
      .i_x     (w_x[g]),
      .i_y     (w_y[g]),
      .i_z     (w_z[g]),
      .i_tag   (w_tag[g]),
      .o_valid (w_v[g+1]),
      .o_x     (w_x[g+1]),
      .o_y     (w_y[g+1]),
      .o_z     (w_z[g+1]),
      .o_tag   (w_tag[g+1])
    );
  end

  logic              w_unused_y;
  logic [PW-1:0]     w_prod;
  logic [WIDTH+1:0]  w_mag_full;
  logic [WIDTH-1:0]  w_mag_sat;
  logic [TW-1:0]     w_tag_end;
  angle_t            w_ang;

  assign w_unused_y = ^w_y[ITERATIONS];
  assign w_tag_end  = w_tag[ITERATIONS];

  // x is non-negative after the pre-rotation
  assign w_prod = PW'($unsigned(w_x[ITERATIONS])) * PW'(CORDIC_K);
  assign w_mag_full = (WIDTH+2)'(w_prod >> (16 + GUARD));
  assign w_mag_sat = (|w_mag_full[WIDTH+1:WIDTH]) ? '1
                   : w_mag_full[WIDTH-1:0];

  assign w_ang = w_tag_end[1] ? (w_tag_end[0] ? PI : '0)
               : angle_clamp(w_z[ITERATIONS]);

  logic              r_vg;
  angle_t            r_angg;
  logic [WIDTH-1:0]  r_magg;
  logic [CHAN_W-1:0] r_chg;

  // Gain compensation, magnitude saturation and angle clamp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vg   <= 1'b0;
      r_angg <= '0;
      r_magg <= '0;
      r_chg  <= '0;
    end else begin
      r_vg   <= w_v[ITERATIONS];
      r_angg <= w_ang;
      r_magg <= w_mag_sat;
      r_chg  <= w_tag_end[TW-1:2];
    end
  end

  logic              r_vo;
  angle_t            r_ango;
  logic [WIDTH-1:0]  r_mago;
  logic [CHAN_W-1:0] r_cho;

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vo   <= 1'b0;
      r_ango <= '0;
      r_mago <= '0;
      r_cho  <= '0;
    end else begin
      r_vo   <= r_vg;
      r_ango <= r_angg;
      r_mago <= r_magg;
      r_cho  <= r_chg;
    end
  end

  assign source_valid = r_vo;
  assign source_angle = r_ango;
  assign source_mag   = r_mago;
  assign source_chan  = r_cho;

endmodule
